// File: rtl/fib_seq_engine_if.sv
// Handshake and result bus of the Fibonacci sequence engine.
// The engine attaches through the slave modport; the requester through master.
interface fib_seq_engine_if #(
    parameter int DATA_W = 16,
    parameter int IDX_W  = 6
);
    logic              start;
    logic [IDX_W-1:0]  n;
    logic              stream_mode;
    logic              abort;
    logic              busy;
    logic              term_valid;
    logic [DATA_W-1:0] term_data;
    logic [IDX_W-1:0]  term_idx;
    logic              done;
    logic [DATA_W-1:0] result;
    logic              ovf;

    modport master (
        output start, n, stream_mode, abort,
        input  busy, term_valid, term_data, term_idx, done, result, ovf
    );

    modport slave (
        input  start, n, stream_mode, abort,
        output busy, term_valid, term_data, term_idx, done, result, ovf
    );
endinterface

// File: rtl/fib_seq_engine.sv
// Fibonacci sequence engine: returns F(n) mod 2^DATA_W with an exact overflow
// flag, optionally streaming every term F(0)..F(n) one per clock.
// The pair (a, b) always holds (F(k), F(k+1)); ovf_a/ovf_b are sticky flags
// telling whether the true value of each term has reached 2^DATA_W.
module fib_seq_engine #(
    parameter int DATA_W = 16,
    parameter int IDX_W  = 6
) (
    input  logic           clk,
    input  logic           rst,
    fib_seq_engine_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [IDX_W-1:0]  k_q, k_d;
    logic [IDX_W-1:0]  nl_q, nl_d;
    logic              mode_q, mode_d;
    logic              ovfa_q, ovfa_d;
    logic              ovfb_q, ovfb_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              ovf_q, ovf_d;
    logic              done_q, done_d;
    logic [DATA_W:0]   sum;

    // Register every piece of state; reset returns to an idle, zeroed engine.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            k_q      <= '0;
            nl_q     <= '0;
            mode_q   <= 1'b0;
            ovfa_q   <= 1'b0;
            ovfb_q   <= 1'b0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            k_q      <= k_d;
            nl_q     <= nl_d;
            mode_q   <= mode_d;
            ovfa_q   <= ovfa_d;
            ovfb_q   <= ovfb_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
        end
    end

    // Next-state logic: latch on start, step the pair each RUN cycle, compare
    // k against n before stepping so the top index never wraps, abort first.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        k_d      = k_q;
        nl_d     = nl_q;
        mode_d   = mode_q;
        ovfa_d   = ovfa_q;
        ovfb_d   = ovfb_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        done_d   = 1'b0;
        sum      = {1'b0, a_q} + {1'b0, b_q};
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    nl_d    = bus.n;
                    mode_d  = bus.stream_mode;
                    a_d     = '0;
                    b_d     = {{(DATA_W-1){1'b0}}, 1'b1};
                    k_d     = '0;
                    ovfa_d  = 1'b0;
                    ovfb_d  = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (k_q == nl_q) begin
                    result_d = a_q;
                    ovf_d    = ovfa_q;
                    done_d   = 1'b1;
                    state_d  = DONE;
                end else begin
                    a_d    = b_q;
                    b_d    = sum[DATA_W-1:0];
                    k_d    = k_q + 1'b1;
                    ovfa_d = ovfb_q;
                    ovfb_d = ovfa_q | ovfb_q | sum[DATA_W];
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.busy       = (state_q == RUN) || (state_q == DONE);
    assign bus.term_valid = (state_q == RUN) && mode_q;
    assign bus.term_data  = a_q;
    assign bus.term_idx   = k_q;
    assign bus.done       = done_q;
    assign bus.result     = result_q;
    assign bus.ovf        = ovf_q;

endmodule

// File: tb/tb_fib_seq_engine.sv
// Bench for the Fibonacci engine: a 16-bit and an 8-bit instance run side by
// side on the same requests and are compared against true Fibonacci values.
module tb_fib_seq_engine;

    logic clk;
    logic rst;
    logic start;
    logic [5:0] nIn;
    logic modeIn;
    logic abortIn;

    int passCount;
    int totalCount;
    logic [63:0] prevRes16, prevRes8;
    logic [63:0] prevOvf16, prevOvf8;

    fib_seq_engine_if #(.DATA_W(16), .IDX_W(6)) bus16 ();
    fib_seq_engine_if #(.DATA_W(8),  .IDX_W(6)) bus8 ();

    assign bus16.start       = start;
    assign bus16.n           = nIn;
    assign bus16.stream_mode = modeIn;
    assign bus16.abort       = abortIn;
    assign bus8.start        = start;
    assign bus8.n            = nIn;
    assign bus8.stream_mode  = modeIn;
    assign bus8.abort        = abortIn;

    fib_seq_engine #(.DATA_W(16), .IDX_W(6)) dut16 (.clk(clk), .rst(rst), .bus(bus16));
    fib_seq_engine #(.DATA_W(8),  .IDX_W(6)) dut8  (.clk(clk), .rst(rst), .bus(bus8));

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // True (unbounded) Fibonacci number, exact up to F(93).
    function automatic longint unsigned fibTrue(input int k);
        longint unsigned x, y, t;
        x = 0;
        y = 1;
        for (int i = 0; i < k; i++) begin
            t = x + y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    function automatic logic [63:0] fibMod(input int k, input int w);
        return 64'(fibTrue(k) & ((64'd1 << w) - 64'd1));
    endfunction

    function automatic logic [63:0] fibOvf(input int k, input int w);
        return ((fibTrue(k) >> w) != 64'd0) ? 64'd1 : 64'd0;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        totalCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, " busy16"}, 64'(bus16.busy), 64'd0);
        checkOutput({tag, " done16"}, 64'(bus16.done), 64'd0);
        checkOutput({tag, " busy8"},  64'(bus8.busy),  64'd0);
        checkOutput({tag, " done8"},  64'(bus8.done),  64'd0);
    endtask

    // One request: start at the next negedge, then walk through RUN cycle by
    // cycle. abortAt/glitchAt/rstAt name the RUN cycle (1-based) for that event.
    task automatic applyStimulus(input int nv, input bit mode, input int abortAt,
                                 input int glitchAt, input int rstAt);
        @(negedge clk);
        start  = 1'b1;
        nIn    = 6'(nv);
        modeIn = mode;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= nv + 1; c++) begin
            checkOutput("run busy16", 64'(bus16.busy), 64'd1);
            checkOutput("run done16", 64'(bus16.done), 64'd0);
            checkOutput("run valid16", 64'(bus16.term_valid), 64'(mode));
            checkOutput("run valid8", 64'(bus8.term_valid), 64'(mode));
            if (mode) begin
                checkOutput("term idx16", 64'(bus16.term_idx), 64'(c - 1));
                checkOutput("term data16", 64'(bus16.term_data), fibMod(c - 1, 16));
                checkOutput("term data8", 64'(bus8.term_data), fibMod(c - 1, 8));
            end
            start = 1'b0;
            if (c == glitchAt) begin
                start  = 1'b1;
                nIn    = 6'd3;
                modeIn = ~mode;
            end
            if (c == abortAt) begin
                abortIn = 1'b1;
                @(negedge clk);
                abortIn = 1'b0;
                start   = 1'b0;
                checkIdle("abort");
                checkOutput("abort result16", 64'(bus16.result), prevRes16);
                checkOutput("abort ovf16", 64'(bus16.ovf), prevOvf16);
                checkOutput("abort result8", 64'(bus8.result), prevRes8);
                checkOutput("abort ovf8", 64'(bus8.ovf), prevOvf8);
                @(negedge clk);
                checkIdle("post abort");
                return;
            end
            if (c == rstAt) begin
                rst = 1'b1;
                @(negedge clk);
                rst   = 1'b0;
                start = 1'b0;
                checkIdle("reset mid");
                checkOutput("reset valid16", 64'(bus16.term_valid), 64'd0);
                checkOutput("reset data16", 64'(bus16.term_data), 64'd0);
                checkOutput("reset idx16", 64'(bus16.term_idx), 64'd0);
                checkOutput("reset result16", 64'(bus16.result), 64'd0);
                checkOutput("reset ovf8", 64'(bus8.ovf), 64'd0);
                prevRes16 = 64'd0;
                prevOvf16 = 64'd0;
                prevRes8  = 64'd0;
                prevOvf8  = 64'd0;
                @(negedge clk);
                checkIdle("post reset");
                return;
            end
            @(negedge clk);
        end
        start = 1'b0;
        prevRes16 = fibMod(nv, 16);
        prevOvf16 = fibOvf(nv, 16);
        prevRes8  = fibMod(nv, 8);
        prevOvf8  = fibOvf(nv, 8);
        checkOutput("done16", 64'(bus16.done), 64'd1);
        checkOutput("done busy16", 64'(bus16.busy), 64'd1);
        checkOutput("done valid16", 64'(bus16.term_valid), 64'd0);
        checkOutput("result16", 64'(bus16.result), prevRes16);
        checkOutput("ovf16", 64'(bus16.ovf), prevOvf16);
        checkOutput("done8", 64'(bus8.done), 64'd1);
        checkOutput("result8", 64'(bus8.result), prevRes8);
        checkOutput("ovf8", 64'(bus8.ovf), prevOvf8);
        @(negedge clk);
        checkIdle("after done");
        checkOutput("hold result16", 64'(bus16.result), prevRes16);
    endtask

    // Directed scenarios first, then randomized requests against the model.
    initial begin
        int nv;
        int ab;
        bit md;
        passCount  = 0;
        totalCount = 0;
        rst     = 1'b1;
        start   = 1'b0;
        nIn     = '0;
        modeIn  = 1'b0;
        abortIn = 1'b0;
        prevRes16 = 64'd0;
        prevOvf16 = 64'd0;
        prevRes8  = 64'd0;
        prevOvf8  = 64'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checkIdle("reset");
        checkOutput("reset result16", 64'(bus16.result), 64'd0);
        checkOutput("reset ovf16", 64'(bus16.ovf), 64'd0);
        checkOutput("reset valid8", 64'(bus8.term_valid), 64'd0);
        checkOutput("reset data8", 64'(bus8.term_data), 64'd0);

        applyStimulus(0, 1'b0, 0, 0, 0);
        applyStimulus(10, 1'b0, 0, 0, 0);
        checkOutput("f10", 64'(bus16.result), 64'd55);
        applyStimulus(13, 1'b0, 0, 0, 0);
        checkOutput("f13 w8", 64'(bus8.result), 64'd233);
        checkOutput("f13 w8 ovf", 64'(bus8.ovf), 64'd0);
        applyStimulus(14, 1'b0, 0, 0, 0);
        checkOutput("f14 w8", 64'(bus8.result), 64'd121);
        checkOutput("f14 w8 ovf", 64'(bus8.ovf), 64'd1);
        applyStimulus(5, 1'b1, 0, 0, 0);
        applyStimulus(20, 1'b0, 0, 4, 0);
        checkOutput("f20", 64'(bus16.result), 64'd6765);
        applyStimulus(20, 1'b1, 5, 0, 0);
        checkOutput("f20 kept", 64'(bus16.result), 64'd6765);
        applyStimulus(8, 1'b0, 0, 0, 3);
        applyStimulus(8, 1'b0, 0, 0, 0);
        checkOutput("f8", 64'(bus16.result), 64'd21);
        applyStimulus(63, 1'b1, 0, 0, 0);
        applyStimulus(1, 1'b0, 1, 0, 0);

        for (int r = 0; r < 20; r++) begin
            nv = int'($urandom_range(63, 0));
            md = 1'($urandom_range(1, 0));
            ab = 0;
            if ($urandom_range(3, 0) == 0) ab = int'($urandom_range(nv + 1, 1));
            applyStimulus(nv, md, ab, 0, 0);
        end

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
